clk_div_gen: RTL and testbench



---
 rtl/clk_gen_pkg.sv | 19 +
 rtl/clk_div_ch.sv | 106 ++++++++++
 rtl/clk_div_gen.sv | 77 +++++++
 tb/tb_clk_div_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Successor to the fixed 25 MHz / 1 kHz generator: the old divisors live on
// here as named constants so callers can ask for them by meaning.
package clk_gen_pkg;

   // Smallest divisor that still yields a real clock (one high, one low cycle).
   localparam int unsigned DIV_MIN         = 32'd2;
   // 100 MHz / 4 = 25 MHz, the legacy pixel/peripheral rate.
   localparam int unsigned DEFAULT_DIV_25M = 32'd4;
   // 100 MHz / 100000 = 1 kHz, the legacy housekeeping rate.
   localparam int unsigned DIV_1K          = 32'd100000;

   // High-phase length of a divided clock: ceil(d/2), so odd divisors get
   // the extra cycle in the high phase (div 3 -> 110).
   function automatic logic [31:0] half_len(input logic [31:0] d);
      return (d + 32'd1) >> 32'd1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active/shadow divisor pair with a
// pending flag, and registered clk_out/tick derived from next-state values
// so both are glitch-free and aligned with the counter.
module clk_div_ch
   import clk_gen_pkg::*;
#(
   parameter int DIV_W       = 20,
   parameter int DEFAULT_DIV = 4
)(
   input  logic             clk_in_100M,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync_start,
   input  logic             wr_en,
   input  logic [DIV_W-1:0] wr_div,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [DIV_W-1:0] ONE_C = DIV_W'(1);
   localparam logic [DIV_W-1:0] DEF_C = DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] cnt_r;
   logic [DIV_W-1:0] active_div_r;
   logic [DIV_W-1:0] shadow_r;
   logic             pending_r;
   logic             en_q_r;
   logic             clk_out_r;
   logic             tick_r;

   logic             terminal_s;
   logic             apply_s;
   logic [DIV_W-1:0] cnt_nxt_s;
   logic [DIV_W-1:0] active_nxt_s;
   logic [DIV_W-1:0] shadow_nxt_s;
   logic             pending_nxt_s;
   logic             clk_nxt_s;
   logic             tick_nxt_s;

   // Next-state logic: counting, boundary apply of the shadow divisor, output decode.
   always_comb begin
      terminal_s    = en && (cnt_r == (active_div_r - ONE_C));
      // Pending shadow goes live at the period boundary, on a sync restart,
      // or right away while the channel is stopped.
      apply_s       = pending_r && (!en || sync_start || terminal_s);

      if (apply_s) begin
         active_nxt_s = shadow_r;
      end else begin
         active_nxt_s = active_div_r;
      end

      if (wr_en) begin
         shadow_nxt_s = wr_div;
      end else begin
         shadow_nxt_s = shadow_r;
      end

      // A write in the apply cycle refills the shadow, so pending stays set.
      if (wr_en) begin
         pending_nxt_s = 1'b1;
      end else if (apply_s) begin
         pending_nxt_s = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end

      // The first enabled cycle after a stop holds cnt at 0 so counting
      // restarts from a full high phase.
      if (!en || !en_q_r || sync_start || terminal_s) begin
         cnt_nxt_s = '0;
      end else begin
         cnt_nxt_s = cnt_r + ONE_C;
      end

      clk_nxt_s  = en && (32'(cnt_nxt_s) < half_len(32'(active_nxt_s)));
      tick_nxt_s = en && (cnt_nxt_s == (active_nxt_s - ONE_C));
   end

   // State and output registers; reset loads the default divisor.
   always_ff @(posedge clk_in_100M or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r        <= '0;
         active_div_r <= DEF_C;
         shadow_r     <= DEF_C;
         pending_r    <= 1'b0;
         en_q_r       <= 1'b0;
         clk_out_r    <= 1'b0;
         tick_r       <= 1'b0;
      end else begin
         cnt_r        <= cnt_nxt_s;
         active_div_r <= active_nxt_s;
         shadow_r     <= shadow_nxt_s;
         pending_r    <= pending_nxt_s;
         en_q_r       <= en;
         clk_out_r    <= clk_nxt_s;
         tick_r       <= tick_nxt_s;
      end
   end

   assign pending = pending_r;
   assign clk_out = clk_out_r;
   assign tick    = tick_r;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider top: validates config writes, returns a
// one-cycle ack/err, and fans the write out to N_CH divider channels.
module clk_div_gen
   import clk_gen_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DIV_W       = 20,
   parameter int DEFAULT_DIV = DEFAULT_DIV_25M,
   parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
)(
   input  logic             clk_in_100M,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  ch_en,
   input  logic             sync_start,
   input  logic             cfg_valid,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ack,
   output logic             cfg_err,
   output logic [N_CH-1:0]  pending,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick
);

   localparam int unsigned      N_CH_U    = N_CH;
   localparam logic [DIV_W-1:0] DIV_MIN_C = DIV_W'(DIV_MIN);

   logic            cfg_ok_s;
   logic [N_CH-1:0] wr_en_s;
   logic            cfg_ack_r;
   logic            cfg_err_r;

   // Validate the write and decode it into a one-hot per-channel strobe.
   always_comb begin
      cfg_ok_s = cfg_valid && (cfg_div >= DIV_MIN_C) && (32'(cfg_ch) < N_CH_U);
      wr_en_s  = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_ok_s && (cfg_ch == CH_W'(i))) begin
            wr_en_s[i] = 1'b1;
         end else begin
            wr_en_s[i] = 1'b0;
         end
      end
   end

   // Registered handshake: exactly one of ack/err per sampled write.
   always_ff @(posedge clk_in_100M or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ack_r <= 1'b0;
         cfg_err_r <= 1'b0;
      end else begin
         cfg_ack_r <= cfg_ok_s;
         cfg_err_r <= cfg_valid && !cfg_ok_s;
      end
   end

   assign cfg_ack = cfg_ack_r;
   assign cfg_err = cfg_err_r;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      clk_div_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in_100M (clk_in_100M),
         .rst_n       (rst_n),
         .en          (ch_en[g]),
         .sync_start  (sync_start),
         .wr_en       (wr_en_s[g]),
         .wr_div      (cfg_div),
         .pending     (pending[g]),
         .clk_out     (clk_out[g]),
         .tick        (tick[g])
      );
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: a config-write vector table plus
// hand-written multi-cycle sequences for the apply/sync/enable corners.
module tb_clk_div_gen;
   import clk_gen_pkg::*;

   logic clk_in_100M = 1'b0;
   always #5 clk_in_100M = ~clk_in_100M;

   logic        rst_n      = 1'b0;
   // four-channel instance
   logic [3:0]  ch_en4     = 4'd0;
   logic        sync4      = 1'b0;
   logic        cfg_valid4 = 1'b0;
   logic [1:0]  cfg_ch4    = 2'd0;
   logic [19:0] cfg_div4   = 20'd0;
   logic        ack4, err4;
   logic [3:0]  pending4, clk_out4, tick4;
   // three-channel instance (out-of-range channel code exists)
   logic [2:0]  ch_en3     = 3'd0;
   logic        sync3      = 1'b0;
   logic        cfg_valid3 = 1'b0;
   logic [1:0]  cfg_ch3    = 2'd0;
   logic [19:0] cfg_div3   = 20'd0;
   logic        ack3, err3;
   logic [2:0]  pending3, clk_out3, tick3;

   clk_div_gen u_dut4 (
      .clk_in_100M (clk_in_100M), .rst_n (rst_n), .ch_en (ch_en4),
      .sync_start (sync4), .cfg_valid (cfg_valid4), .cfg_ch (cfg_ch4),
      .cfg_div (cfg_div4), .cfg_ack (ack4), .cfg_err (err4),
      .pending (pending4), .clk_out (clk_out4), .tick (tick4)
   );

   clk_div_gen #(.N_CH(3)) u_dut3 (
      .clk_in_100M (clk_in_100M), .rst_n (rst_n), .ch_en (ch_en3),
      .sync_start (sync3), .cfg_valid (cfg_valid3), .cfg_ch (cfg_ch3),
      .cfg_div (cfg_div3), .cfg_ack (ack3), .cfg_err (err3),
      .pending (pending3), .clk_out (clk_out3), .tick (tick3)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit          dut3;
      logic [1:0]  ch;
      logic [19:0] div;
      logic        ack;
      logic        err;
      logic [3:0]  pend;
   } vec_t;
   vec_t vecs[10];

   logic [3:0] clk_h4[64];
   logic [3:0] tick_h4[64];
   logic [3:0] pend_h4[64];
   logic [2:0] clk_h3[64];

   task automatic step();
      @(posedge clk_in_100M);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Record n cycles of outputs; entry 0 is the current (already settled) state.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) step();
         clk_h4[i]  = clk_out4;
         tick_h4[i] = tick4;
         pend_h4[i] = pending4;
         clk_h3[i]  = clk_out3;
      end
   endtask

   // Pack one channel's history MSB-first (first captured cycle is the MSB).
   function automatic logic [63:0] hist(input int sel, input int ch, input int n);
      logic [63:0] p;
      logic        b;
      p = '0;
      for (int i = 0; i < n; i++) begin
         case (sel)
            0:       b = clk_h4[i][ch];
            1:       b = tick_h4[i][ch];
            2:       b = pend_h4[i][ch];
            default: b = clk_h3[i][ch];
         endcase
         p = {p[62:0], b};
      end
      return p;
   endfunction

   task automatic wait_tick(input int ch, input string name);
      int k;
      k = 0;
      while (!tick4[ch] && k < 20) begin
         step();
         k++;
      end
      check(name, 64'(tick4[ch]), 64'd1);
   endtask

   task automatic cfg4(input logic [1:0] ch, input logic [19:0] div);
      cfg_valid4 = 1'b1;
      cfg_ch4    = ch;
      cfg_div4   = div;
      step();
      cfg_valid4 = 1'b0;
   endtask

   initial begin
      logic [63:0] both;
      int          k, h, t;

      vecs[0] = '{1'b0, 2'd0, 20'd2,      1'b1, 1'b0, 4'b0001};
      vecs[1] = '{1'b0, 2'd0, 20'd1,      1'b0, 1'b1, 4'b0000};
      vecs[2] = '{1'b0, 2'd2, 20'd0,      1'b0, 1'b1, 4'b0000};
      vecs[3] = '{1'b0, 2'd1, 20'd7,      1'b1, 1'b0, 4'b0010};
      vecs[4] = '{1'b0, 2'd1, 20'd3,      1'b1, 1'b0, 4'b0010};
      vecs[5] = '{1'b0, 2'd3, 20'hFFFFF,  1'b1, 1'b0, 4'b1000};
      vecs[6] = '{1'b1, 2'd0, 20'd3,      1'b1, 1'b0, 4'b0001};
      vecs[7] = '{1'b1, 2'd0, 20'd1,      1'b0, 1'b1, 4'b0000};
      vecs[8] = '{1'b1, 2'd3, 20'd2,      1'b0, 1'b1, 4'b0000};
      vecs[9] = '{1'b1, 2'd2, 20'd2,      1'b1, 1'b0, 4'b0100};

      // reset state
      step(); step(); step();
      check("rst clk_out", 64'(clk_out4), 64'd0);
      check("rst tick", 64'(tick4), 64'd0);
      check("rst pending", 64'(pending4), 64'd0);
      check("rst ack/err", 64'({ack4, err4}), 64'd0);
      check("rst clk_out3", 64'(clk_out3), 64'd0);
      rst_n = 1'b1;
      step();

      // config table, all channels stopped so valid writes apply next clock
      for (int v = 0; v < 10; v++) begin
         if (vecs[v].dut3) begin
            cfg_valid3 = 1'b1; cfg_ch3 = vecs[v].ch; cfg_div3 = vecs[v].div;
         end else begin
            cfg_valid4 = 1'b1; cfg_ch4 = vecs[v].ch; cfg_div4 = vecs[v].div;
         end
         step();
         cfg_valid3 = 1'b0;
         cfg_valid4 = 1'b0;
         if (vecs[v].dut3) begin
            check($sformatf("vec%0d ack", v), 64'(ack3), 64'(vecs[v].ack));
            check($sformatf("vec%0d err", v), 64'(err3), 64'(vecs[v].err));
            check($sformatf("vec%0d pend", v), 64'(pending3), 64'(vecs[v].pend));
         end else begin
            check($sformatf("vec%0d ack", v), 64'(ack4), 64'(vecs[v].ack));
            check($sformatf("vec%0d err", v), 64'(err4), 64'(vecs[v].err));
            check($sformatf("vec%0d pend", v), 64'(pending4), 64'(vecs[v].pend));
         end
         step();
         check($sformatf("vec%0d applied", v), 64'({pending4, 1'b0, pending3}), 64'd0);
         check($sformatf("vec%0d ack/err pulse", v), 64'({ack4, err4, ack3, err3}), 64'd0);
      end

      // enable everything: table divisors take effect, rejected writes left no trace
      ch_en4 = 4'hF;
      ch_en3 = 3'h7;
      step();
      capture(6);
      check("d3 ch0 div3", hist(3, 0, 6), 64'b110110);
      check("d3 ch1 div4", hist(3, 1, 6), 64'b110011);
      check("d3 ch2 div2", hist(3, 2, 6), 64'b101010);
      check("d4 ch0 div2", hist(0, 0, 6), 64'b101010);
      check("d4 ch1 div3", hist(0, 1, 6), 64'b110110);
      check("d4 ch2 div4", hist(0, 2, 6), 64'b110011);
      check("d4 ch3 divmax", hist(0, 3, 6), 64'b111111);

      // asynchronous reset mid-period
      cfg4(2'd2, 20'd5);
      check("pre-rst ack", 64'(ack4), 64'd1);
      check("pre-rst pend", 64'(pending4[2]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst ack", 64'(ack4), 64'd0);
      check("async rst pend", 64'(pending4), 64'd0);
      check("async rst clk", 64'({clk_out4, 1'b0, clk_out3}), 64'd0);
      check("async rst tick", 64'({tick4, 1'b0, tick3}), 64'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      capture(8);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("dflt clk ch%0d", c), hist(0, c, 8), 64'b11001100);
         check($sformatf("dflt tick ch%0d", c), hist(1, c, 8), 64'b00010001);
         check($sformatf("dflt pend ch%0d", c), hist(2, c, 8), 64'd0);
      end
      check("dflt d3 ch0", hist(3, 0, 8), 64'b11001100);

      // ch2: div3 then div5 within one period, only the last is applied
      wait_tick(2, "p6 align");
      step();
      cfg4(2'd2, 20'd3);
      check("p6 ack1", 64'({ack4, err4}), 64'b10);
      check("p6 pend1", 64'(pending4[2]), 64'd1);
      cfg4(2'd2, 20'd5);
      check("p6 ack2", 64'({ack4, err4}), 64'b10);
      step();
      check("p6 old period tick", 64'(tick4[2]), 64'd1);
      check("p6 pend held", 64'(pending4[2]), 64'd1);
      step();
      capture(10);
      check("p6 clk div5", hist(0, 2, 10), 64'b1110011100);
      check("p6 tick div5", hist(1, 2, 10), 64'b0000100001);
      check("p6 pend clr", hist(2, 2, 10), 64'd0);

      // ch1 at the 1 kHz divisor
      cfg4(2'd1, 20'(DIV_1K));
      check("1k ack", 64'(ack4), 64'd1);
      check("1k pend", 64'(pending4[1]), 64'd1);
      k = 0;
      while (pending4[1] && k < 10) begin
         step();
         k++;
      end
      check("1k applied", 64'(pending4[1]), 64'd0);
      check("1k apply within period", 64'(k >= 1 && k <= 4), 64'd1);
      h = 0;
      t = 0;
      while (clk_out4[1] && h < 60000) begin
         h++;
         if (tick4[1]) t++;
         step();
      end
      check("1k high phase", 64'(h), 64'd50000);
      check("1k no tick in high", 64'(t), 64'd0);

      // write on the terminal cycle, nothing pending: old divisor runs one more period
      wait_tick(3, "pA align");
      cfg4(2'd3, 20'd6);
      check("pA pend", 64'(pending4[3]), 64'd1);
      capture(10);
      check("pA clk", hist(0, 3, 10), 64'b1100111000);
      check("pA tick", hist(1, 3, 10), 64'b0001000001);
      check("pA pend hist", hist(2, 3, 10), 64'b1111000000);

      // write on the terminal cycle with a pending shadow: old shadow applies, new waits
      cfg4(2'd0, 20'd8);
      wait_tick(0, "pB align");
      cfg4(2'd0, 20'd2);
      capture(10);
      check("pB clk", hist(0, 0, 10), 64'b1111000010);
      check("pB tick", hist(1, 0, 10), 64'b0000000101);
      check("pB pend hist", hist(2, 0, 10), 64'b1111111100);

      // sync_start with simultaneous write; ticks of div 4/6/8 meet at cycle 24
      cfg4(2'd0, 20'd4);
      cfg4(2'd1, 20'd6);
      cfg4(2'd2, 20'd8);
      cfg_valid4 = 1'b1; cfg_ch4 = 2'd3; cfg_div4 = 20'd2; sync4 = 1'b1;
      step();
      cfg_valid4 = 1'b0;
      sync4 = 1'b0;
      check("sync clk", 64'(clk_out4), 64'hF);
      check("sync tick", 64'(tick4), 64'd0);
      check("sync pend", 64'(pending4), 64'b1000);
      check("sync ack", 64'(ack4), 64'd1);
      capture(24);
      both = '0;
      for (int i = 0; i < 24; i++) both = {both[62:0], &tick_h4[i][2:0]};
      check("sync lcm tick", both, 64'd1);
      check("sync tick ch0", hist(1, 0, 24), 64'h111111);
      check("sync tick ch1", hist(1, 1, 24), 64'h041041);
      check("sync tick ch2", hist(1, 2, 24), 64'h010101);
      check("sync clk ch2", hist(0, 2, 24), 64'hF0F0F0);

      // ch_en[0] toggle; disabled channel applies its write on the next clock
      ch_en4 = 4'b1110;
      step();
      check("dis clk", 64'({clk_out4[0], tick4[0]}), 64'd0);
      cfg4(2'd0, 20'd2);
      check("dis pend", 64'(pending4[0]), 64'd1);
      step();
      check("dis applied", 64'(pending4[0]), 64'd0);
      check("dis clk held", 64'(clk_out4[0]), 64'd0);
      ch_en4 = 4'hF;
      step();
      capture(8);
      check("reen clk", hist(0, 0, 8), 64'b10101010);
      check("reen tick", hist(1, 0, 8), 64'b01010101);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
